gerenciador_tiros_param: RTL and testbench
==========================================

Name: gerenciador_tiros_param

Overview:
- Parametrised shot manager for the asteroids game core. It replaces the fixed single-shot register/move pair.
- Holds up to N_TIROS concurrent shots, each with a position and one of 8 directions.
- Loads new shots at the ship position on request and advances all live shots one slot per cycle on each game tick.
- Retires shots that leave the playfield, and clears shots on collision-kill requests from the asteroid comparator.

Parameters:
- N_TIROS, 4, number of shot slots (1..16).
- COORD_W, 6, coordinate width in bits.
- LARGURA, 64, playfield width; legal x is 0..LARGURA-1.
- ALTURA, 48, playfield height; legal y is 0..ALTURA-1.
- VELOCIDADE, 1, cells moved per tick on each active axis.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- disparar  in  1  fire request, single-cycle pulse.
- direcao  in  3  shot direction: 0=N(y-1), 1=NE, 2=E, 3=SE, 4=S, 5=SW, 6=W, 7=NW.
- nave_x, nave_y  in  COORD_W each  ship position.
- passo  in  1  game tick pulse; starts a move pass.
- destruir  in  1  kill request pulse.
- destruir_idx  in  4  slot to kill.
- tiros_valido  out  N_TIROS  per-slot live flag.
- tiros_x, tiros_y  out  N_TIROS*COORD_W each  flattened positions; slot i occupies bits [i*COORD_W +: COORD_W].
- disparo_aceito  out  1  one-cycle pulse when a shot is loaded.
- disparo_rejeitado  out  1  one-cycle pulse when a fire request is dropped.
- cheio  out  1  all slots live.
- num_tiros  out  $clog2(N_TIROS+1)  count of live slots.
- pronto  out  1  one-cycle pulse at the end of a move pass.
- db_estado  out  2  FSM state.

Behaviour:
- Reset: clears all outputs, valid flags, coordinates, directions, the pending latch and the slot index. FSM goes to OCIOSO. Reset mid-pass aborts the pass and pronto is not pulsed.
- FSM encoding: OCIOSO=0, MOVE=1, FIM=2.
- OCIOSO + passo: go to MOVE with idx=0.
- MOVE: processes slot idx each cycle, idx increments; at idx==N_TIROS-1 go to FIM.
- FIM: pronto=1 for one cycle, then OCIOSO.
- Latency: passo sampled at edge t gives pronto high during cycle t+N_TIROS+1.
- passo outside OCIOSO is ignored.
- Move rule:
  - Each axis computes next = pos ± VELOCIDADE, in COORD_W+1 signed arithmetic.
  - If either axis leaves its legal range, valid is cleared and the coordinates are held.
  - Otherwise the position is updated.
  - Invalid slots are untouched.
- Fire handling in OCIOSO:
  - Picks the lowest-index free slot.
  - Loads nave_x, nave_y and direcao at the next edge, sets valid, and pulses disparo_aceito in the following cycle.
  - If no slot is free (cheio), disparo_rejeitado pulses and state is unchanged.
- Fire handling in MOVE or FIM:
  - The request is captured in a one-deep pending latch (direction plus ship coordinates as sampled).
  - It is serviced on the first OCIOSO cycle.
  - A second request while the latch is full is rejected.
- disparar together with passo in OCIOSO: the shot loads at the same edge that enters MOVE, and it is moved in that same pass.
- destruir:
  - Accepted in any state.
  - Clears valid of destruir_idx at the next edge.
  - destruir_idx >= N_TIROS is a no-op.
  - Takes priority over the move update of the same slot in the same cycle.
  - Does not block a load into a different free slot.
- cheio and num_tiros are registered views of the valid vector; they update in the cycle after any valid change.

Decomposition:
- Package gerenciador_tiros_pkg:
  - Direction encoding constants DIR_N..DIR_NW.
  - FSM state constants.
  - Function returning (dx, dy) in {-1,0,+1} for a direction.
- Sub-module calcula_passo_tiro: combinational. Takes x, y and direction and outputs next_x, next_y and fora_limite. One instance is shared by the MOVE datapath through the idx mux.

Test Plan:
- Reset, then disparar with direcao=2 and nave=(10,20) → slot0 valid at (10,20), disparo_aceito pulse, num_tiros=1. Then passo → slot0 at (11,20); pronto 5 cycles after the passo edge (N_TIROS=4).
- Shot at (0,5) with direcao=6, then passo → slot0 valid cleared, num_tiros=0, coordinates held at (0,5).
- Five disparar pulses in OCIOSO → slots 0..3 valid and cheio=1; the fifth gives disparo_rejeitado with no state change.
- disparar during MOVE → held in the latch and loaded into the lowest free slot right after pronto; a second disparar in the same pass → disparo_rejeitado.
- destruir with destruir_idx=1 in the cycle MOVE processes slot1 → slot1 invalid and not updated; destruir_idx=7 → no effect.
- reset asserted mid-MOVE → all valid=0, db_estado=0 next cycle, no pronto pulse.

Source files
------------

// File: rtl/gerenciador_tiros_pkg.sv
// Shared types and helpers for the parametrised shot manager.
// Direction encoding, FSM states and the per-direction unit step.
package gerenciador_tiros_pkg;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        MOVE   = 2'd1,
        FIM    = 2'd2
    } estado_t;

    typedef enum logic [2:0] {
        DIR_N  = 3'd0,
        DIR_NE = 3'd1,
        DIR_E  = 3'd2,
        DIR_SE = 3'd3,
        DIR_S  = 3'd4,
        DIR_SW = 3'd5,
        DIR_W  = 3'd6,
        DIR_NW = 3'd7
    } direcao_t;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } delta_t;

    localparam logic signed [1:0] D_MENOS = 2'sb11;
    localparam logic signed [1:0] D_ZERO  = 2'sb00;
    localparam logic signed [1:0] D_MAIS  = 2'sb01;

    // Screen convention: y grows downwards, so north is y-1.
    function automatic delta_t delta_direcao(input direcao_t d);
        delta_t r;
        case (d)
            DIR_N:   r = '{dx: D_ZERO,  dy: D_MENOS};
            DIR_NE:  r = '{dx: D_MAIS,  dy: D_MENOS};
            DIR_E:   r = '{dx: D_MAIS,  dy: D_ZERO};
            DIR_SE:  r = '{dx: D_MAIS,  dy: D_MAIS};
            DIR_S:   r = '{dx: D_ZERO,  dy: D_MAIS};
            DIR_SW:  r = '{dx: D_MENOS, dy: D_MAIS};
            DIR_W:   r = '{dx: D_MENOS, dy: D_ZERO};
            default: r = '{dx: D_MENOS, dy: D_MENOS};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gerenciador_tiros_calcula_passo.sv
// Combinational single-step mover for one shot.
// Computes the next position and flags when it would leave the playfield.
module calcula_passo_tiro
    import gerenciador_tiros_pkg::*;
#(
    parameter int COORD_W    = 6,
    parameter int LARGURA    = 64,
    parameter int ALTURA     = 48,
    parameter int VELOCIDADE = 1
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [2:0]         direcao,
    output logic [COORD_W-1:0] next_x,
    output logic [COORD_W-1:0] next_y,
    output logic               fora_limite
);

    localparam logic signed [COORD_W:0] VEL = (COORD_W+1)'(VELOCIDADE);

    function automatic logic signed [COORD_W:0] avanca(
        input logic signed [COORD_W:0] p,
        input logic signed [1:0]       d
    );
        case (d)
            D_MAIS:  return p + VEL;
            D_MENOS: return p - VEL;
            default: return p;
        endcase
    endfunction

    delta_t                  delta;
    logic signed [COORD_W:0] nx;
    logic signed [COORD_W:0] ny;

    // One extra signed bit: a negative result or a wrap past the top of the
    // signed range both show up in the sign bit and count as out of range.
    always_comb begin
        delta       = delta_direcao(direcao_t'(direcao));
        nx          = avanca($signed({1'b0, x}), delta.dx);
        ny          = avanca($signed({1'b0, y}), delta.dy);
        fora_limite = nx[COORD_W] || ny[COORD_W] ||
                      (int'(nx) >= LARGURA) || (int'(ny) >= ALTURA);
        next_x      = nx[COORD_W-1:0];
        next_y      = ny[COORD_W-1:0];
    end

endmodule

// File: rtl/gerenciador_tiros_param.sv
// Parametrised shot manager: loads shots at the ship, advances them one slot
// per cycle on each game tick, retires out-of-range and killed shots.
module gerenciador_tiros_param
    import gerenciador_tiros_pkg::*;
#(
    parameter int N_TIROS    = 4,
    parameter int COORD_W    = 6,
    parameter int LARGURA    = 64,
    parameter int ALTURA     = 48,
    parameter int VELOCIDADE = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         disparar,
    input  logic [2:0]                   direcao,
    input  logic [COORD_W-1:0]           nave_x,
    input  logic [COORD_W-1:0]           nave_y,
    input  logic                         passo,
    input  logic                         destruir,
    input  logic [3:0]                   destruir_idx,
    output logic [N_TIROS-1:0]           tiros_valido,
    output logic [N_TIROS*COORD_W-1:0]   tiros_x,
    output logic [N_TIROS*COORD_W-1:0]   tiros_y,
    output logic                         disparo_aceito,
    output logic                         disparo_rejeitado,
    output logic                         cheio,
    output logic [$clog2(N_TIROS+1)-1:0] num_tiros,
    output logic                         pronto,
    output logic [1:0]                   db_estado
);

    localparam int IDX_W = (N_TIROS > 1) ? $clog2(N_TIROS) : 1;
    localparam int CNT_W = $clog2(N_TIROS+1);

    estado_t            estado;
    estado_t            prox_estado;
    logic [IDX_W-1:0]   idx;

    logic [N_TIROS-1:0] valido;
    logic [COORD_W-1:0] pos_x [N_TIROS];
    logic [COORD_W-1:0] pos_y [N_TIROS];
    logic [2:0]         dir   [N_TIROS];

    logic               pend_valido;
    logic [2:0]         pend_dir;
    logic [COORD_W-1:0] pend_x;
    logic [COORD_W-1:0] pend_y;

    logic               ocioso;
    logic               move_en;
    logic               pronto_d;

    logic [IDX_W-1:0]   livre_idx;
    logic               tem_livre;
    logic               req_ativo;
    logic               carrega;
    logic               captura;
    logic               rejeita;
    logic [2:0]         req_dir;
    logic [COORD_W-1:0] req_x;
    logic [COORD_W-1:0] req_y;
    logic [CNT_W-1:0]   contagem;

    logic [COORD_W-1:0] mv_next_x;
    logic [COORD_W-1:0] mv_next_y;
    logic               mv_fora;

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) estado <= OCIOSO;
        else       estado <= prox_estado;
    end

    // FSM: next state
    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:  if (passo) prox_estado = MOVE;
            MOVE:    if (idx == IDX_W'(N_TIROS-1)) prox_estado = FIM;
            FIM:     prox_estado = OCIOSO;
            default: prox_estado = OCIOSO;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ocioso   = (estado == OCIOSO);
        move_en  = (estado == MOVE);
        pronto_d = (estado == FIM);
    end

    calcula_passo_tiro #(
        .COORD_W    (COORD_W),
        .LARGURA    (LARGURA),
        .ALTURA     (ALTURA),
        .VELOCIDADE (VELOCIDADE)
    ) u_passo (
        .x           (pos_x[idx]),
        .y           (pos_y[idx]),
        .direcao     (dir[idx]),
        .next_x      (mv_next_x),
        .next_y      (mv_next_y),
        .fora_limite (mv_fora)
    );

    always_comb begin
        livre_idx = '0;
        tem_livre = 1'b0;
        contagem  = '0;
        for (int unsigned i = N_TIROS; i > 0; i--) begin
            if (!valido[i-1]) begin
                livre_idx = IDX_W'(i-1);
                tem_livre = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N_TIROS; i++)
            contagem = contagem + CNT_W'(valido[i]);
    end

    // In OCIOSO a held request is served before a fresh one; a fresh one
    // arriving while the latch is still full is dropped.
    always_comb begin
        req_ativo = ocioso && (pend_valido || disparar);
        req_dir   = pend_valido ? pend_dir : direcao;
        req_x     = pend_valido ? pend_x   : nave_x;
        req_y     = pend_valido ? pend_y   : nave_y;
        carrega   = req_ativo && tem_livre;
        captura   = !ocioso && disparar && !pend_valido;
        rejeita   = (req_ativo && !tem_livre) || (disparar && pend_valido);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_valido <= 1'b0;
            pend_dir    <= '0;
            pend_x      <= '0;
            pend_y      <= '0;
        end else if (ocioso && pend_valido) begin
            pend_valido <= 1'b0;
        end else if (captura) begin
            pend_valido <= 1'b1;
            pend_dir    <= direcao;
            pend_x      <= nave_x;
            pend_y      <= nave_y;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)                idx <= '0;
        else if (ocioso && passo) idx <= '0;
        else if (move_en)         idx <= idx + IDX_W'(1);
    end

    // A load only targets a free slot, so it never collides with a kill of a
    // live shot; a kill still beats the move of its own slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            valido <= '0;
            for (int unsigned i = 0; i < N_TIROS; i++) begin
                pos_x[i] <= '0;
                pos_y[i] <= '0;
                dir[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_TIROS; i++) begin
                if (carrega && livre_idx == IDX_W'(i)) begin
                    valido[i] <= 1'b1;
                    pos_x[i]  <= req_x;
                    pos_y[i]  <= req_y;
                    dir[i]    <= req_dir;
                end else if (destruir && destruir_idx == 4'(i)) begin
                    valido[i] <= 1'b0;
                end else if (move_en && idx == IDX_W'(i) && valido[i]) begin
                    if (mv_fora) begin
                        valido[i] <= 1'b0;
                    end else begin
                        pos_x[i] <= mv_next_x;
                        pos_y[i] <= mv_next_y;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            disparo_aceito    <= 1'b0;
            disparo_rejeitado <= 1'b0;
            pronto            <= 1'b0;
            cheio             <= 1'b0;
            num_tiros         <= '0;
        end else begin
            disparo_aceito    <= carrega;
            disparo_rejeitado <= rejeita;
            pronto            <= pronto_d;
            cheio             <= &valido;
            num_tiros         <= contagem;
        end
    end

    always_comb begin
        tiros_valido = valido;
        db_estado    = estado;
        for (int unsigned i = 0; i < N_TIROS; i++) begin
            tiros_x[i*COORD_W +: COORD_W] = pos_x[i];
            tiros_y[i*COORD_W +: COORD_W] = pos_y[i];
        end
    end

endmodule

// File: tb/tb_gerenciador_tiros_param.sv
// Directed self-checking bench for gerenciador_tiros_param (N_TIROS=4).
module tb_gerenciador_tiros_param;

    logic        clock = 1'b0;
    logic        reset;
    logic        disparar;
    logic [2:0]  direcao;
    logic [5:0]  nave_x;
    logic [5:0]  nave_y;
    logic        passo;
    logic        destruir;
    logic [3:0]  destruir_idx;
    logic [3:0]  tiros_valido;
    logic [23:0] tiros_x;
    logic [23:0] tiros_y;
    logic        disparo_aceito;
    logic        disparo_rejeitado;
    logic        cheio;
    logic [2:0]  num_tiros;
    logic        pronto;
    logic [1:0]  db_estado;

    int total = 0;
    int bad   = 0;

    gerenciador_tiros_param #(
        .N_TIROS    (4),
        .COORD_W    (6),
        .LARGURA    (64),
        .ALTURA     (48),
        .VELOCIDADE (1)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .disparar          (disparar),
        .direcao           (direcao),
        .nave_x            (nave_x),
        .nave_y            (nave_y),
        .passo             (passo),
        .destruir          (destruir),
        .destruir_idx      (destruir_idx),
        .tiros_valido      (tiros_valido),
        .tiros_x           (tiros_x),
        .tiros_y           (tiros_y),
        .disparo_aceito    (disparo_aceito),
        .disparo_rejeitado (disparo_rejeitado),
        .cheio             (cheio),
        .num_tiros         (num_tiros),
        .pronto            (pronto),
        .db_estado         (db_estado)
    );

    always #5 clock = ~clock;

    task automatic checar(input string tag, input int obs, input int esp);
        total++;
        if (obs != esp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    task automatic ciclo(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic int px(input int i);
        return int'(tiros_x[i*6 +: 6]);
    endfunction

    function automatic int py(input int i);
        return int'(tiros_y[i*6 +: 6]);
    endfunction

    task automatic aplica_reset();
        reset = 1'b1;
        ciclo(2);
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        disparar     = 1'b0;
        direcao      = 3'd0;
        nave_x       = '0;
        nave_y       = '0;
        passo        = 1'b0;
        destruir     = 1'b0;
        destruir_idx = '0;
        ciclo(2);
        checar("rst_valido", tiros_valido, 0);
        checar("rst_num", num_tiros, 0);
        checar("rst_cheio", cheio, 0);
        checar("rst_estado", db_estado, 0);
        checar("rst_pronto", pronto, 0);
        reset = 1'b0;

        // single shot east from (10,20), then one pass
        disparar = 1'b1; direcao = 3'd2; nave_x = 6'd10; nave_y = 6'd20;
        ciclo(1);
        disparar = 1'b0;
        checar("t1_valido", tiros_valido, 4'b0001);
        checar("t1_x", px(0), 10);
        checar("t1_y", py(0), 20);
        checar("t1_aceito", disparo_aceito, 1);
        ciclo(1);
        checar("t1_aceito_fim", disparo_aceito, 0);
        checar("t1_num", num_tiros, 1);
        passo = 1'b1;
        ciclo(1);
        passo = 1'b0;
        checar("t1_estado_move", db_estado, 1);
        for (int k = 1; k <= 6; k++) begin
            ciclo(1);
            checar($sformatf("t1_pronto_k%0d", k), pronto, (k == 5) ? 1 : 0);
            if (k == 4) checar("t1_estado_fim", db_estado, 2);
        end
        checar("t1_x_mov", px(0), 11);
        checar("t1_y_mov", py(0), 20);

        // shot west at the left border retires, coordinates held
        aplica_reset();
        disparar = 1'b1; direcao = 3'd6; nave_x = 6'd0; nave_y = 6'd5;
        ciclo(1);
        disparar = 1'b0;
        passo = 1'b1;
        ciclo(1);
        passo = 1'b0;
        ciclo(6);
        checar("t2_valido", tiros_valido, 0);
        checar("t2_num", num_tiros, 0);
        checar("t2_x", px(0), 0);
        checar("t2_y", py(0), 5);

        // five consecutive fire requests, south, slot k at (5k,10)
        aplica_reset();
        disparar = 1'b1; direcao = 3'd4; nave_y = 6'd10;
        for (int k = 0; k < 5; k++) begin
            nave_x = 6'(5*k);
            ciclo(1);
            if (k == 3) checar("t3_aceito4", disparo_aceito, 1);
        end
        disparar = 1'b0;
        checar("t3_rejeitado", disparo_rejeitado, 1);
        checar("t3_aceito5", disparo_aceito, 0);
        ciclo(1);
        checar("t3_cheio", cheio, 1);
        checar("t3_num", num_tiros, 4);
        checar("t3_valido", tiros_valido, 4'b1111);
        checar("t3_x0", px(0), 0);
        checar("t3_x3", px(3), 15);

        // free slot 2, then fire twice during a pass
        destruir = 1'b1; destruir_idx = 4'd2;
        ciclo(1);
        destruir = 1'b0;
        checar("t4_kill", tiros_valido, 4'b1011);
        passo = 1'b1;
        ciclo(1);
        passo = 1'b0;
        disparar = 1'b1; direcao = 3'd0; nave_x = 6'd30; nave_y = 6'd30;
        ciclo(1);
        checar("t4_latch_sem_rej", disparo_rejeitado, 0);
        checar("t4_latch_sem_acc", disparo_aceito, 0);
        nave_x = 6'd50; nave_y = 6'd50;
        ciclo(1);
        disparar = 1'b0;
        checar("t4_segundo_rej", disparo_rejeitado, 1);
        ciclo(3);
        checar("t4_pronto", pronto, 1);
        checar("t4_antes_carga", tiros_valido, 4'b1011);
        ciclo(1);
        checar("t4_aceito", disparo_aceito, 1);
        checar("t4_valido", tiros_valido, 4'b1111);
        checar("t4_x2", px(2), 30);
        checar("t4_y2", py(2), 30);
        checar("t4_y0", py(0), 11);

        // kill slot 1 exactly while it is being moved; idx 7 does nothing
        passo = 1'b1;
        ciclo(1);
        passo = 1'b0;
        ciclo(1);
        destruir = 1'b1; destruir_idx = 4'd1;
        ciclo(1);
        destruir_idx = 4'd7;
        checar("t5_valido1", tiros_valido, 4'b1101);
        checar("t5_y1", py(1), 11);
        ciclo(1);
        destruir = 1'b0;
        checar("t5_idx7", tiros_valido, 4'b1101);
        checar("t5_y2", py(2), 29);
        ciclo(3);
        checar("t5_y3", py(3), 12);

        // reset in the middle of a pass
        passo = 1'b1;
        ciclo(1);
        passo = 1'b0;
        ciclo(1);
        reset = 1'b1;
        ciclo(1);
        reset = 1'b0;
        checar("t6_valido", tiros_valido, 0);
        checar("t6_estado", db_estado, 0);
        for (int k = 0; k < 6; k++) begin
            checar($sformatf("t6_pronto_%0d", k), pronto, 0);
            ciclo(1);
        end

        // fire and tick together: loaded and moved in the same pass
        disparar = 1'b1; passo = 1'b1; direcao = 3'd3; nave_x = 6'd10; nave_y = 6'd20;
        ciclo(1);
        disparar = 1'b0; passo = 1'b0;
        checar("t7_estado", db_estado, 1);
        ciclo(5);
        checar("t7_pronto", pronto, 1);
        checar("t7_x", px(0), 11);
        checar("t7_y", py(0), 21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
